// File: rtl/avalon_pwm_pkg.sv
// Shared register map and bit positions for the multi-channel Avalon PWM block.
package avalon_pwm_pkg;

   // Word offsets of the register map
   localparam int unsigned OFS_CTRL    = 32'd0;
   localparam int unsigned OFS_PERIOD  = 32'd1;
   localparam int unsigned OFS_POL     = 32'd2;
   localparam int unsigned OFS_STATUS  = 32'd3;
   localparam int unsigned OFS_DUTY0   = 32'd4;

   // CTRL bit positions
   localparam int unsigned CTRL_RUN    = 32'd0;
   localparam int unsigned CTRL_COMMIT = 32'd1;
   localparam int unsigned CTRL_IRQ_EN = 32'd2;

   // STATUS bit positions
   localparam int unsigned STAT_WRAP   = 32'd0;
   localparam int unsigned STAT_PEND   = 32'd1;

endpackage

// File: rtl/avalon_pwm_multi_channel.sv
// One PWM channel: active duty register loaded at the shared load point,
// unsigned compare against the shared counter, polarity XOR, output flop.
module pwm_channel #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CNT_W-1:0] duty_sh_i,
   input  logic             run_i,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic             pol_i,
   output logic             pwm_o
);

   logic [CNT_W-1:0] duty_a_q;
   logic [CNT_W-1:0] duty_a_d;
   logic             pwm_q;
   logic             pwm_d;

   // Take the shadow duty only at the load point so a period never sees a partial update
   always_comb begin
      duty_a_d = duty_a_q;
      if (load_i) begin
         duty_a_d = duty_sh_i;
      end else begin
         duty_a_d = duty_a_q;
      end
   end

   // Active while counter is below duty; polarity flips the idle/active levels
   always_comb begin
      pwm_d = (run_i & (cnt_i < duty_a_q)) ^ pol_i;
   end

   // Active duty and registered output
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         duty_a_q <= {CNT_W{1'b0}};
         pwm_q    <= 1'b0;
      end else begin
         duty_a_q <= duty_a_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/avalon_pwm_multi.sv
// Multi-channel PWM with Avalon-MM slave: shadowed period/duty committed at
// period wrap, per-channel polarity, sticky wrap flag and level interrupt.
module avalon_pwm_multi
   import avalon_pwm_pkg::*;
#(
   parameter int N_CH   = 6,
   parameter int CNT_W  = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic              avs_read,
   output logic [31:0]       avs_readdata,
   output logic [N_CH-1:0]   pwm_out,
   output logic              irq
);

   logic             run_q, run_d;
   logic             irq_en_q, irq_en_d;
   logic [CNT_W-1:0] period_sh_q, period_sh_d;
   logic [N_CH-1:0]  pol_q, pol_d;
   logic [CNT_W-1:0] duty_sh_q [N_CH];
   logic [CNT_W-1:0] duty_sh_d [N_CH];
   logic             pending_q, pending_d;
   logic             wrap_q, wrap_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_a_q, period_a_d;
   logic             irq_q, irq_d;
   logic [31:0]      rdata_q, rdata_d;

   logic             wr_ctrl_s, wr_status_s, commit_s;
   logic             at_end_s, load_s;
   logic [31:0]      rd_s;
   logic [N_CH-1:0]  pwm_s;
   logic             unused_wdata_s;

   assign unused_wdata_s = ^avs_writedata;

   // Address decode and the shared load point
   always_comb begin
      wr_ctrl_s   = avs_write & (avs_address == ADDR_W'(OFS_CTRL));
      wr_status_s = avs_write & (avs_address == ADDR_W'(OFS_STATUS));
      commit_s    = wr_ctrl_s & avs_writedata[CTRL_COMMIT];
      at_end_s    = run_q & (cnt_q == period_a_q);
      load_s      = pending_q & (at_end_s | ~run_q);
   end

   // Shadow register writes; bits above each field width are dropped
   always_comb begin
      run_d       = run_q;
      irq_en_d    = irq_en_q;
      period_sh_d = period_sh_q;
      pol_d       = pol_q;
      duty_sh_d   = duty_sh_q;
      if (wr_ctrl_s) begin
         run_d    = avs_writedata[CTRL_RUN];
         irq_en_d = avs_writedata[CTRL_IRQ_EN];
      end else begin
         run_d    = run_q;
         irq_en_d = irq_en_q;
      end
      if (avs_write && (avs_address == ADDR_W'(OFS_PERIOD))) begin
         period_sh_d = avs_writedata[CNT_W-1:0];
      end else begin
         period_sh_d = period_sh_q;
      end
      if (avs_write && (avs_address == ADDR_W'(OFS_POL))) begin
         pol_d = avs_writedata[N_CH-1:0];
      end else begin
         pol_d = pol_q;
      end
      for (int i = 0; i < N_CH; i++) begin
         if (avs_write && (avs_address == ADDR_W'(OFS_DUTY0 + i))) begin
            duty_sh_d[i] = avs_writedata[CNT_W-1:0];
         end else begin
            duty_sh_d[i] = duty_sh_q[i];
         end
      end
   end

   // Pending, counter, active period, wrap flag and irq next state
   always_comb begin
      pending_d  = pending_q;
      cnt_d      = cnt_q;
      period_a_d = period_a_q;
      wrap_d     = wrap_q;
      // a commit landing on a load cycle must survive for the next load
      if (commit_s) begin
         pending_d = 1'b1;
      end else if (load_s) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end
      if (!run_q) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (at_end_s) begin
         cnt_d = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (load_s) begin
         period_a_d = period_sh_q;
      end else begin
         period_a_d = period_a_q;
      end
      // a wrap in the same cycle as a W1C keeps the flag set
      if (at_end_s) begin
         wrap_d = 1'b1;
      end else if (wr_status_s && avs_writedata[STAT_WRAP]) begin
         wrap_d = 1'b0;
      end else begin
         wrap_d = wrap_q;
      end
      irq_d = wrap_q & irq_en_q;
   end

   // Readback of shadow values; unmapped addresses read 0
   always_comb begin
      rd_s = 32'd0;
      case (avs_address)
         ADDR_W'(OFS_CTRL): begin
            rd_s[CTRL_RUN]    = run_q;
            rd_s[CTRL_IRQ_EN] = irq_en_q;
         end
         ADDR_W'(OFS_PERIOD): rd_s = 32'(period_sh_q);
         ADDR_W'(OFS_POL):    rd_s = 32'(pol_q);
         ADDR_W'(OFS_STATUS): begin
            rd_s[STAT_WRAP] = wrap_q;
            rd_s[STAT_PEND] = pending_q;
         end
         default: begin
            for (int i = 0; i < N_CH; i++) begin
               rd_s = rd_s | ((avs_address == ADDR_W'(OFS_DUTY0 + i)) ? 32'(duty_sh_q[i]) : 32'd0);
            end
         end
      endcase
      rdata_d = avs_read ? rd_s : 32'd0;
   end

   // All block state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_q       <= 1'b0;
         irq_en_q    <= 1'b0;
         period_sh_q <= {CNT_W{1'b0}};
         pol_q       <= {N_CH{1'b0}};
         for (int i = 0; i < N_CH; i++) begin
            duty_sh_q[i] <= {CNT_W{1'b0}};
         end
         pending_q   <= 1'b0;
         wrap_q      <= 1'b0;
         cnt_q       <= {CNT_W{1'b0}};
         period_a_q  <= {CNT_W{1'b0}};
         irq_q       <= 1'b0;
         rdata_q     <= 32'd0;
      end else begin
         run_q       <= run_d;
         irq_en_q    <= irq_en_d;
         period_sh_q <= period_sh_d;
         pol_q       <= pol_d;
         duty_sh_q   <= duty_sh_d;
         pending_q   <= pending_d;
         wrap_q      <= wrap_d;
         cnt_q       <= cnt_d;
         period_a_q  <= period_a_d;
         irq_q       <= irq_d;
         rdata_q     <= rdata_d;
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      pwm_channel #(.CNT_W(CNT_W)) u_ch (
         .clk       (clk),
         .reset     (reset),
         .load_i    (load_s),
         .duty_sh_i (duty_sh_q[g]),
         .run_i     (run_q),
         .cnt_i     (cnt_q),
         .pol_i     (pol_q[g]),
         .pwm_o     (pwm_s[g])
      );
   end

   assign pwm_out      = pwm_s;
   assign irq          = irq_q;
   assign avs_readdata = rdata_q;

endmodule
